// File: rtl/float_expand_pkg.sv
// Shared types and helpers for the float_expand_seq widening converter.
// Holds the converter state encoding, the operand class record and the
// exponent-bias helper used by every file of the block.
package float_expand_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } FloatExpandState;

  typedef struct packed {
    logic isZero;
    logic isDenormal;
    logic isInf;
    logic isNan;
  } FloatClass;

  // IEEE-style exponent bias for an exponent field of expW bits.
  function automatic int bias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  // Classifies an operand from its field summaries so the helper stays
  // independent of the operand widths.
  function automatic FloatClass classify(input logic expZero,
                                         input logic expOnes,
                                         input logic fracZero);
    FloatClass c;
    c.isZero     = expZero && fracZero;
    c.isDenormal = expZero && !fracZero;
    c.isInf      = expOnes && fracZero;
    c.isNan      = expOnes && !fracZero;
    return c;
  endfunction

endpackage

// File: rtl/float_expand_norm.sv
// Iterative renormaliser for denormal fractions.
// start_i loads the operand and clears the shift count; each following
// cycle shifts left by one until the leading one reaches the MSB, at which
// point done_o pulses with the fraction below the hidden bit and p_o equal
// to the number of leading zeros. Only started on a nonzero operand; the
// count limit keeps the shifter from running away if that is ever violated.
module float_expand_norm
  import float_expand_pkg::*;
#(
  parameter int FRAC_W = 23,
  parameter int PW     = $clog2(FRAC_W + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic [FRAC_W-1:0] operand_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [FRAC_W-2:0] fraction_o,
  output logic [PW-1:0]     p_o
);

  localparam logic [PW-1:0] P_MAX = PW'(FRAC_W - 1);

  logic [FRAC_W-1:0] shift_q, shift_d;
  logic [PW-1:0]     p_q, p_d;
  logic              busy_q, busy_d;
  logic              found;

  assign found      = shift_q[FRAC_W-1] || (p_q == P_MAX);
  assign done_o     = busy_q && found;
  assign busy_o     = busy_q;
  assign fraction_o = shift_q[FRAC_W-2:0];
  assign p_o        = p_q;

  // Next-state: load on start, otherwise shift one place per cycle until the leading one is found.
  always_comb begin
    shift_d = shift_q;
    p_d     = p_q;
    busy_d  = busy_q;
    if (start_i) begin
      shift_d = operand_i;
      p_d     = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (found) begin
        busy_d = 1'b0;
      end else begin
        shift_d = shift_q << 1;
        p_d     = p_q + PW'(1);
      end
    end
  end

  // Shifter, count and busy registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/float_expand_seq.sv
// Streaming widening float converter: Float(EXP_IN,FRAC_IN) -> Float(EXP_OUT,FRAC_OUT)
// with valid/ready on both sides and a single-entry output register.
// Normals, zeros, infinities and NaNs convert in one cycle and can stream at
// one word per cycle. Denormals are renormalised by float_expand_norm at one
// bit per cycle (latency = leading zeros + 2) and then parked in HOLD.
// Build option: define FLOAT_EXPAND_DAZ_EN to flush denormal inputs to signed
// zero in one cycle instead of renormalising them.
module float_expand_seq
  import float_expand_pkg::*;
#(
  parameter int EXP_IN   = 3,
  parameter int FRAC_IN  = 23,
  parameter int EXP_OUT  = 4,
  parameter int FRAC_OUT = 23
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [EXP_IN+FRAC_IN:0]       in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [EXP_OUT+FRAC_OUT:0]     out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_is_nan,
  output logic                          out_was_denormal
);

  localparam int BIAS_IN  = bias(EXP_IN);
  localparam int BIAS_OUT = bias(EXP_OUT);
  localparam int PW       = $clog2(FRAC_IN + 1);
  localparam int FRAC_PAD = FRAC_OUT - FRAC_IN;
  localparam logic [EXP_OUT-1:0] EXP_ADJ  = EXP_OUT'(BIAS_OUT - BIAS_IN);
  localparam logic [EXP_OUT-1:0] EXP_ONES = '1;
  localparam bit SAME_EXP = (EXP_OUT == EXP_IN);

`ifdef FLOAT_EXPAND_DAZ_EN
  localparam bit DAZ_EN = 1'b1;
`else
  localparam bit DAZ_EN = 1'b0;
`endif

  // Configurations that cannot represent every input exactly are rejected at elaboration.
  if (EXP_OUT < EXP_IN || FRAC_OUT < FRAC_IN) begin : gBadWidths
    $error("float_expand_seq: output format must not be narrower than the input format");
  end
  if (!SAME_EXP && (BIAS_OUT - BIAS_IN - (FRAC_IN - 1)) < 1) begin : gBadRange
    $error("float_expand_seq: output exponent range too small to renormalise every input denormal");
  end

  FloatExpandState state_q, state_d;

  logic [EXP_OUT+FRAC_OUT:0] outData_q, outData_d;
  logic                      outValid_q, outValid_d;
  logic                      outIsNan_q, outIsNan_d;
  logic                      outWasDenormal_q, outWasDenormal_d;
  logic                      normSign_q, normSign_d;

  logic               inSign;
  logic [EXP_IN-1:0]  inExp;
  logic [FRAC_IN-1:0] inFrac;
  FloatClass          inClass;
  logic               inReady;
  logic               renormNeeded;

  logic [EXP_OUT-1:0]  directExp;
  logic [FRAC_OUT-1:0] directFrac;

  logic               normStart;
  logic               normBusy;
  logic               normDone;
  logic [FRAC_IN-2:0] normFrac;
  logic [PW-1:0]      normP;
  logic [EXP_OUT-1:0]  normExp;
  logic [FRAC_OUT-1:0] normFracOut;

  assign {inSign, inExp, inFrac} = in_data;
  assign inClass      = classify(inExp == '0, inExp == '1, inFrac == '0);
  assign renormNeeded = inClass.isDenormal && !DAZ_EN && !SAME_EXP;

  assign inReady          = (state_q == IDLE) && (!outValid_q || out_ready);
  assign in_ready         = inReady;
  assign out_data         = outData_q;
  assign out_valid        = outValid_q;
  assign out_is_nan       = outIsNan_q;
  assign out_was_denormal = outWasDenormal_q;

  // Single-cycle conversion for everything that does not need renormalising.
  always_comb begin
    directExp  = EXP_OUT'(inExp) + EXP_ADJ;
    directFrac = FRAC_OUT'(inFrac) << FRAC_PAD;
    if (inClass.isZero || inClass.isDenormal) begin
      directExp = '0;
    end else if (inClass.isInf || inClass.isNan) begin
      directExp = EXP_ONES;
    end
    if (inClass.isDenormal && DAZ_EN) begin
      directFrac = '0;
    end
  end

  float_expand_norm #(
    .FRAC_W (FRAC_IN),
    .PW     (PW)
  ) uNorm (
    .clock      (clock),
    .reset      (reset),
    .start_i    (normStart),
    .operand_i  (inFrac),
    .busy_o     (normBusy),
    .done_o     (normDone),
    .fraction_o (normFrac),
    .p_o        (normP)
  );

  assign normExp     = EXP_ADJ - EXP_OUT'(normP);
  assign normFracOut = FRAC_OUT'({normFrac, 1'b0}) << FRAC_PAD;

  // Control: accept/drain in IDLE, wait for the shifter in NORM, stall in HOLD until drained.
  always_comb begin
    state_d          = state_q;
    outData_d        = outData_q;
    outValid_d       = outValid_q;
    outIsNan_d       = outIsNan_q;
    outWasDenormal_d = outWasDenormal_q;
    normSign_d       = normSign_q;
    normStart        = 1'b0;
    case (state_q)
      IDLE: begin
        if (outValid_q && out_ready) begin
          outValid_d = 1'b0;
        end
        if (in_valid && inReady) begin
          if (renormNeeded) begin
            normStart  = 1'b1;
            normSign_d = inSign;
            state_d    = NORM;
          end else begin
            outData_d        = {inSign, directExp, directFrac};
            outValid_d       = 1'b1;
            outIsNan_d       = inClass.isNan;
            outWasDenormal_d = inClass.isDenormal;
          end
        end
      end
      NORM: begin
        if (normDone) begin
          outData_d        = {normSign_q, normExp, normFracOut};
          outValid_d       = 1'b1;
          outIsNan_d       = 1'b0;
          outWasDenormal_d = 1'b1;
          state_d          = HOLD;
        end else if (!normBusy) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output register; reset discards any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      outData_q        <= '0;
      outValid_q       <= 1'b0;
      outIsNan_q       <= 1'b0;
      outWasDenormal_q <= 1'b0;
      normSign_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      outData_q        <= outData_d;
      outValid_q       <= outValid_d;
      outIsNan_q       <= outIsNan_d;
      outWasDenormal_q <= outWasDenormal_d;
      normSign_q       <= normSign_d;
    end
  end

endmodule

// File: tb/tb_float_expand_seq.sv
// Directed self-checking bench for float_expand_seq in the single -> double
// configuration (8,23)->(11,52). Expected words are hand-computed IEEE doubles;
// denormal expectations switch when FLOAT_EXPAND_DAZ_EN is defined.
module tb_float_expand_seq;

  localparam int EI = 8;
  localparam int FI = 23;
  localparam int EO = 11;
  localparam int FO = 52;

`ifdef FLOAT_EXPAND_DAZ_EN
  localparam bit DAZ = 1'b1;
`else
  localparam bit DAZ = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_nan;
  logic        out_was_denormal;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  float_expand_seq #(
    .EXP_IN   (EI),
    .FRAC_IN  (FI),
    .EXP_OUT  (EO),
    .FRAC_OUT (FO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_is_nan       (out_is_nan),
    .out_was_denormal (out_was_denormal)
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Offers one word, waits (bounded) for acceptance, then counts cycles until out_valid.
  task automatic applyStimulus(input logic [31:0] word, output int lat);
    int guard;
    guard = 0;
    @(negedge clock);
    in_data  = word;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  // One conversion with latency, data and both flags checked.
  task automatic convertCheck(input string tag, input logic [31:0] word, input logic [63:0] expData,
                              input int expLat, input logic expNan, input logic expDen);
    int lat;
    applyStimulus(word, lat);
    checkOutput({tag, ".lat"}, 64'(lat), 64'(expLat));
    checkOutput({tag, ".data"}, out_data, expData);
    checkOutput({tag, ".isNan"}, 64'(out_is_nan), 64'(expNan));
    checkOutput({tag, ".wasDen"}, 64'(out_was_denormal), 64'(expDen));
  endtask

  // Hard stop in case the bench itself ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] streamIn [3];
    logic [63:0] streamOut [3];
    logic        stray;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rst.outValid", 64'(out_valid), 64'd0);
    checkOutput("rst.inReady", 64'(in_ready), 64'd1);
    checkOutput("rst.outData", out_data, 64'd0);
    checkOutput("rst.isNan", 64'(out_is_nan), 64'd0);
    checkOutput("rst.wasDen", 64'(out_was_denormal), 64'd0);

    $display("[TB] directed conversions");
    convertCheck("one",     32'h3F800000, 64'h3FF0000000000000, 1, 1'b0, 1'b0);
    convertCheck("pi",      32'h40490FDB, 64'h400921FB60000000, 1, 1'b0, 1'b0);
    convertCheck("negInf",  32'hFF800000, 64'hFFF0000000000000, 1, 1'b0, 1'b0);
    convertCheck("nan",     32'h7FC00001, 64'h7FF8000020000000, 1, 1'b1, 1'b0);
    convertCheck("negZero", 32'h80000000, 64'h8000000000000000, 1, 1'b0, 1'b0);
    convertCheck("maxDen",  32'h007FFFFF, DAZ ? 64'h0 : 64'h380FFFFFC0000000, DAZ ? 1 : 2, 1'b0, 1'b1);
    convertCheck("negDen",  32'h80400000, DAZ ? 64'h8000000000000000 : 64'hB800000000000000,
                 DAZ ? 1 : 2, 1'b0, 1'b1);
    convertCheck("den2",    32'h00200000, DAZ ? 64'h0 : 64'h37F0000000000000, DAZ ? 1 : 3, 1'b0, 1'b1);
    convertCheck("den11",   32'h000C0000, DAZ ? 64'h0 : 64'h37D8000000000000, DAZ ? 1 : 5, 1'b0, 1'b1);
    convertCheck("minDen",  32'h00000001, DAZ ? 64'h0 : 64'h36A0000000000000, DAZ ? 1 : 24, 1'b0, 1'b1);

    $display("[TB] back-to-back streaming");
    repeat (2) @(posedge clock);
    streamIn[0] = 32'h3F800000; streamOut[0] = 64'h3FF0000000000000;
    streamIn[1] = 32'h40490FDB; streamOut[1] = 64'h400921FB60000000;
    streamIn[2] = 32'hFF800000; streamOut[2] = 64'hFFF0000000000000;
    @(negedge clock);
    in_data  = streamIn[0];
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("stream%0d.valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("stream%0d.data", i), out_data, streamOut[i]);
      if (i < 2) in_data = streamIn[i + 1];
    end
    in_valid = 1'b0;

    $display("[TB] output backpressure");
    repeat (2) @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    convertCheck("bp", 32'h3F800000, 64'h3FF0000000000000, 1, 1'b0, 1'b0);
    @(negedge clock);
    in_data  = 32'h40000000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      checkOutput("bp.held.data", out_data, 64'h3FF0000000000000);
      checkOutput("bp.held.valid", 64'(out_valid), 64'd1);
      checkOutput("bp.held.inReady", 64'(in_ready), 64'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    in_data   = 32'h40490FDB;
    #1;
    checkOutput("bp.release.inReady", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    checkOutput("bp.release.valid", 64'(out_valid), 64'd1);
    checkOutput("bp.release.data", out_data, 64'h400921FB60000000);
    @(posedge clock);
    #1;
    checkOutput("bp.drained.valid", 64'(out_valid), 64'd0);

    $display("[TB] backpressure on a renormalised word");
    @(negedge clock);
    out_ready = 1'b0;
    convertCheck("bpDen", 32'h00200000, DAZ ? 64'h0 : 64'h37F0000000000000, DAZ ? 1 : 3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checkOutput("bpDen.held.data", out_data, DAZ ? 64'h0 : 64'h37F0000000000000);
      checkOutput("bpDen.held.inReady", 64'(in_ready), 64'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    repeat (2) @(posedge clock);

    $display("[TB] reset during renormalisation");
    @(negedge clock);
    in_data  = 32'h00000001;
    in_valid = 1'b1;
    #1;
    checkOutput("rstNorm.inReady", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rstNorm.outValid", 64'(out_valid), 64'd0);
    checkOutput("rstNorm.inReadyAfter", 64'(in_ready), 64'd1);
    checkOutput("rstNorm.outData", out_data, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) stray = 1'b1;
    end
    checkOutput("rstNorm.noStray", 64'(stray), 64'd0);
    convertCheck("rstNorm.next", 32'h3F800000, 64'h3FF0000000000000, 1, 1'b0, 1'b0);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
